// File: rtl/gf2_stream_pkg.sv
// Shared types for GF(2) word streams: the word type and the per-branch
// skid buffer occupancy states used by the fork and its consumers.
package gf2_stream_pkg;

   localparam int GF2_WIDTH = 16;

   typedef logic [GF2_WIDTH-1:0] gf2_word_t;

   // Occupancy of one skid buffer: main register only drives the output,
   // the skid register catches the word that arrives while the consumer stalls.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/skid_buffer_gf2.sv
// One output branch of the fork: a 2-entry skid buffer (main + skid register).
// The main register always drives the branch output, so data and valid are
// flop outputs and stay stable while the consumer stalls.
module skid_buffer_gf2
   import gf2_stream_pkg::*;
#(
   parameter int WIDTH = GF2_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             full,
   output logic             full_next
);

   skid_state_e      state_q;
   skid_state_e      state_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             valid_q;
   logic             full_q;
   logic             consume;
   logic             load_main;
   logic             load_skid;
   logic             main_from_skid;

   assign consume = valid_q & ready;

   // Next occupancy and which register captures which word this cycle.
   always_comb begin
      // NOTE: every signal assigned below gets a default first so that no path
      // through the case leaves it unassigned and infers a latch.
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (load) begin
               state_d   = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (load && consume) begin
               load_main = 1'b1;
            end else if (load) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // The fork never loads a FULL branch, so only a consume can happen.
            if (consume) begin
               state_d        = ONE;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // The fork's ready flop looks one edge ahead at this branch's occupancy.
   assign full_next = (state_d == FULL);

   // State, registered valid/full flags and the two data registers.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: the data registers are reset as well because the branch output
      // must read zero while reset is held; they are only two words deep.
      if (reset) begin
         state_q <= EMPTY;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state_q <= state_d;
         valid_q <= (state_d != EMPTY);
         full_q  <= (state_d == FULL);
         if (load_main) begin
            main_q <= word;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= word;
         end
      end
   end

   assign data  = main_q;
   assign valid = valid_q;
   assign full  = full_q;

endmodule

// File: rtl/stream_fork_gf2.sv
// Replicates one valid/ready stream of GF(2) words onto two branches, each
// with its own 2-entry skid buffer so the consumers may stall independently.
// o_ready is a flop: it never depends combinationally on any ready input.
module stream_fork_gf2
   import gf2_stream_pkg::*;
#(
   parameter int WIDTH = GF2_WIDTH
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_a_data,
   output logic             o_a_valid,
   input  logic             i_a_ready,
   output logic [WIDTH-1:0] o_b_data,
   output logic             o_b_valid,
   input  logic             i_b_ready
);

   logic accept;
   logic a_full;
   logic a_full_next;
   logic b_full;
   logic b_full_next;

   assign accept = i_valid & o_ready;

   skid_buffer_gf2 #(.WIDTH(WIDTH)) u_branch_a (
      .clock     (i_clock),
      .reset     (i_reset),
      .load      (accept),
      .word      (i_data),
      .data      (o_a_data),
      .valid     (o_a_valid),
      .ready     (i_a_ready),
      .full      (a_full),
      .full_next (a_full_next)
   );

   skid_buffer_gf2 #(.WIDTH(WIDTH)) u_branch_b (
      .clock     (i_clock),
      .reset     (i_reset),
      .load      (accept),
      .word      (i_data),
      .data      (o_b_data),
      .valid     (o_b_valid),
      .ready     (i_b_ready),
      .full      (b_full),
      .full_next (b_full_next)
   );

   // Accept new words only while neither branch will be FULL after this edge.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_ready <= 1'b0;
      end else begin
         o_ready <= ~(a_full_next | b_full_next);
      end
   end

   // A FULL branch has no free register, so an accept into it would drop a word.
   no_load_into_full: assert property (
      @(posedge i_clock) disable iff (i_reset) !(accept && (a_full || b_full))
   );

endmodule

// File: doc/stream_fork_gf2.md
Name: stream_fork_gf2

Overview:
- Replicates one valid/ready stream of WIDTH-bit GF(2) words onto two independent output branches, A and B.
- Its sum stream feeds two consumers, e.g. the lhs and rhs ports of adder_gf2, or a checker plus a downstream adder.
- Each branch has a 2-entry skid buffer, so the two consumers may stall independently while the fork still sustains one word per cycle.
- All outputs are registered, and there is no combinational path from any ready input to o_ready.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- i_clock  in  1  clock, all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  WIDTH  input word.
- i_valid  in  1  input word present.
- o_ready  out  1  fork accepts i_data this cycle.
- o_a_data  out  WIDTH  branch A word.
- o_a_valid  out  1  branch A word present.
- i_a_ready  in  1  branch A consumer accepts.
- o_b_data  out  WIDTH  branch B word.
- o_b_valid  out  1  branch B word present.
- i_b_ready  in  1  branch B consumer accepts.

Behaviour:
- Reset (asynchronous, active-high, honoured mid-operation):
  - o_a_valid=0, o_b_valid=0, o_ready=0, o_a_data=0, o_b_data=0.
  - All skid entries are invalid and in-flight words are discarded.
  - o_ready rises on the first rising edge after i_reset deasserts.
- Per-branch state: main register (drives the output) and skid register. The states are:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid valid.
- Input accept:
  - accept = i_valid & o_ready.
  - o_ready = registered "neither branch FULL, and not in reset".
  - o_ready is a flop output. It depends only on the branch states at the next edge and never on i_valid, i_a_ready or i_b_ready in the same cycle.
  - No word is ever written into a FULL branch.
- On accept, the same i_data is written into both branches. Per branch:
  - EMPTY -> ONE: word loads main.
  - ONE with consume (valid & ready) -> ONE: word loads main.
  - ONE without consume -> FULL: word loads skid.
  - FULL: cannot occur on accept (o_ready was 0).
- Without accept, per branch:
  - ONE with consume -> EMPTY.
  - FULL with consume -> ONE: skid moves to main.
  - Otherwise the state holds.
- Latency and throughput:
  - Latency is 1 cycle: a word accepted at edge N is visible on both outputs after edge N.
  - With both readies held high, throughput is 1 word/cycle.
- Ordering and conservation:
  - Each branch delivers every accepted word exactly once, in acceptance order.
  - There is no duplication and no dropping.
  - The data value is unmodified, bit-exact.
- Stall rules:
  - Branch data and valid stay stable while valid=1 and ready=0 (AXI-style).
  - A branch with its ready low holds at most 2 words. When it reaches FULL, o_ready deasserts at the next edge and stays low until that branch consumes.
  - A branch skew greater than 2 words is impossible.
- Simultaneous events:
  - Accept and consume on the same branch in the same cycle is legal and is handled per the table above.
  - Both branches consuming while the input accepts keeps both branches in ONE.
- i_valid may drop at any time without any transfer. Data on i_data is ignored when i_valid=0.

Decomposition:
- Package gf2_stream_pkg:
  - typedef gf2_word_t, logic [WIDTH-1:0], with default WIDTH 16.
  - enum skid_state_e {EMPTY, ONE, FULL}.
  - Shared by adder_gf2 and this block.
- Sub-module skid_buffer_gf2: one branch, with load input, ready input and full output. It is instantiated twice, for A and B. The top level holds only the accept logic and the o_ready flop.

Test Plan:
- Idle:
  - Stimulus: i_valid=0 for 100 cycles, both readies=1.
  - Response: zero transfers on A and B; o_ready=1 after reset release; outputs 0 during reset.
- Streaming:
  - Stimulus: 12 words 16'hFFFF, 16'hF0F0, 16'h0F0F, 16'h8000, ..., 16'h1101 on consecutive cycles, both readies=1.
  - Response: each branch outputs the same 12 words in order, first word 1 cycle after accept, o_ready never low.
- Branch A stall:
  - Stimulus: i_a_ready=0, i_b_ready=1, send 16'h1001, 16'h0110, 16'h1616.
  - Response: A holds 16'h1001 stable; o_ready=0 after 2 accepts; third word not accepted; B delivers 16'h1001, 16'h0110.
  - Stimulus: raise i_a_ready.
  - Response: A delivers 16'h1001, 16'h0110, then 16'h1616 is accepted and arrives on both branches.
- Alternating backpressure:
  - Stimulus: i_a_ready and i_b_ready each driven pseudo-random (LFSR), 1000 random words with random i_valid gaps.
  - Response: each branch scoreboard matches the input sequence exactly; counts equal on completion.
- Reset mid-operation:
  - Stimulus: assert i_reset asynchronously while both branches are FULL with 16'hB00B, 16'hB005.
  - Response: valids drop immediately without waiting for a clock edge; after release no stale word appears; the next word 16'hBEEF is the first delivered on both branches.
- Chained with adder_gf2:
  - Stimulus: fork A feeds adder lhs, fork B feeds adder rhs, inputs 16'h1234, 16'hAAAA.
  - Response: sum output is 16'h0000 for every word (x XOR x).
